// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial sync-detect / 8-bit / hold-off link.
// Used by the transmitter (serial_frame_tx) and the receiver controller so
// both ends agree on frame geometry and the controller state encoding.
//
// Contents:
//   SYNC_W   - sync pattern length in bits (2..8)
//   SYNC_PAT - sync pattern, sent MSB first
//   DATA_W   - payload width, also the hold-off counter width
//   state_t  - controller state encoding
package serial_link_pkg;

  localparam int SYNC_W = 4;
  localparam logic [SYNC_W-1:0] SYNC_PAT = 4'b1101;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_SYNC = 3'd2,
    ST_DATA = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

endpackage

// File: rtl/serial_frame_tx_downcounter.sv
// tx_downcounter: synchronous loadable down counter used for the hold-off
// period after each frame.
//
// Ports:
//   clk      - clock, all state on posedge
//   rst      - synchronous active-high reset, clears count and flag
//   ld       - load count with d (wins over en)
//   en       - decrement by one; stops at zero, never wraps
//   d        - load value
//   one_flag - registered flag, high exactly when the count equals 1
module tx_downcounter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic         one_flag
);

  logic [W-1:0] count;

  // one_flag is computed from the value the count is about to take, so it is
  // a plain flop output yet always tracks (count == 1) in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      one_flag <= 1'b0;
    end else if (ld) begin
      count    <= d;
      one_flag <= (d == W'(1));
    end else if (en && (count != '0)) begin
      count    <= count - W'(1);
      one_flag <= (count == W'(2));
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: transmit end of the serial sync-detect / 8-bit / hold-off
// link. A start handshake captures one byte; the frame is the sync pattern
// followed by the byte MSB first, then the line is held idle for a number of
// cycles equal to the byte value while the far end counts it down.
//
// Ports:
//   clk        - system clock, all state on posedge
//   rst        - synchronous active-high reset, aborts any frame (no done)
//   start      - frame request level
//   data_in    - payload byte, captured on the IDLE->ARM edge
//   serial_out - serial line, idles at 0
//   ready      - high only in IDLE
//   busy       - high in ARM, SYNC, DATA, HOLD
//   tx_active  - high while sync or data bits are on the line
//   done       - one-cycle pulse in the first IDLE cycle after a frame
//
// Handshake: start is sampled only when ready is high (IDLE). A start seen
// with ready=1 captures data_in and moves to ARM; the frame is launched when
// start is released. While busy is high after ARM, start is ignored. If start
// is high in the first IDLE cycle (the done cycle) the next frame begins.
//
// All outputs decode from registered state; nothing passes combinationally
// from inputs to outputs.
module serial_frame_tx #(
  parameter int                SYNC_W   = serial_link_pkg::SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = serial_link_pkg::SYNC_PAT,
  parameter int                DATA_W   = serial_link_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              serial_out,
  output logic              ready,
  output logic              busy,
  output logic              tx_active,
  output logic              done
);

  import serial_link_pkg::*;

  localparam int CNT_W = (DATA_W > SYNC_W) ? $clog2(DATA_W) : $clog2(SYNC_W);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] byte_q;     // untouched copy of the byte for the hold-off
  logic [CNT_W-1:0]  bit_cnt;
  logic              done_q;

  logic              hold_ld;
  logic              hold_en;
  logic              hold_one;
  logic [SYNC_W-1:0] sync_shift;

  // The hold counter is loaded on the last data bit whatever the byte; for a
  // zero byte HOLD is skipped so the loaded zero is never used.
  assign hold_ld = (state == ST_DATA) && (bit_cnt == DATA_LAST);
  assign hold_en = (state == ST_HOLD);

  tx_downcounter #(
    .W(DATA_W)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .ld       (hold_ld),
    .en       (hold_en),
    .d        (byte_q),
    .one_flag (hold_one)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      byte_q    <= '0;
      bit_cnt   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_ARM;
            shift_reg <= data_in;
            byte_q    <= data_in;
          end
        end
        ST_ARM: begin
          if (!start) begin
            state   <= ST_SYNC;
            bit_cnt <= '0;
          end
        end
        ST_SYNC: begin
          if (bit_cnt == SYNC_LAST) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
          if (bit_cnt == DATA_LAST) begin
            bit_cnt <= '0;
            if (byte_q != '0) begin
              state <= ST_HOLD;
            end else begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (hold_one) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Shifting the pattern left by bit_cnt puts the current sync bit at the
  // MSB, avoiding a variable index of mismatched width.
  assign sync_shift = SYNC_PAT << bit_cnt;

  always_comb begin
    serial_out = 1'b0;
    case (state)
      ST_SYNC: serial_out = sync_shift[SYNC_W-1];
      ST_DATA: serial_out = shift_reg[DATA_W-1];
      default: serial_out = 1'b0;
    endcase
  end

  assign ready     = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign tx_active = (state == ST_SYNC) || (state == ST_DATA);
  assign done      = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Testbench for serial_frame_tx. Each frame pushes its cycle-by-cycle
// expected output word {serial_out, ready, busy, tx_active, done} into a
// queue; the words are popped and compared on every falling edge.
module tb_serial_frame_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] data_in;
  logic       serial_out;
  logic       ready;
  logic       busy;
  logic       tx_active;
  logic       done;

  int checks   = 0;
  int failures = 0;

  logic [4:0] exp_q[$];

  localparam logic [3:0] PAT = 4'b1101;
  localparam logic [4:0] W_IDLE = 5'b01000;
  localparam logic [4:0] W_DONE = 5'b01001;
  localparam logic [4:0] W_BUSY = 5'b00100;  // ARM or HOLD

  typedef struct {
    logic [7:0] data;
    int         arm;
    logic [7:0] alt;
    bit         pulses;
    int         abort_k;
  } vec_t;

  vec_t vecs[8];

  serial_frame_tx dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
    .serial_out (serial_out),
    .ready      (ready),
    .busy       (busy),
    .tx_active  (tx_active),
    .done       (done)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check_word(input string tag, input int pos, input logic [4:0] exp);
    logic [4:0] got;
    got = {serial_out, ready, busy, tx_active, done};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s pos=%0d got{ser,rdy,busy,tx,done}=%b exp=%b", tag, pos, got, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b, input int arm, input bit chain);
    logic [3:0] pat_v;
    pat_v = PAT;
    for (int i = 0; i < arm; i++) exp_q.push_back(W_BUSY);
    for (int i = 0; i < 4; i++) exp_q.push_back({pat_v[3-i], 1'b0, 1'b1, 1'b1, 1'b0});
    for (int i = 0; i < 8; i++) exp_q.push_back({b[7-i], 1'b0, 1'b1, 1'b1, 1'b0});
    for (int i = 0; i < int'(b); i++) exp_q.push_back(W_BUSY);
    exp_q.push_back(W_DONE);
    if (!chain) exp_q.push_back(W_IDLE);
  endtask

  // Called just after a falling edge; drives one frame and checks every cycle.
  task automatic run_frame(input string tag, input logic [7:0] b, input int arm,
                           input logic [7:0] alt, input bit pulses, input int abort_k,
                           input bit pre_started, input bit chain, input logic [7:0] next_b);
    int n;
    int bi;
    logic [4:0] exp;
    bi = int'(b);
    exp_q.delete();
    push_frame(b, arm, chain);
    if (!pre_started) begin
      start   = 1'b1;
      data_in = b;
    end
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      check_word(tag, k, exp);
      if (k == abort_k) begin
        rst   = 1'b1;
        start = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_word({tag, "_abort"}, k + 1, W_IDLE);
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          check_word({tag, "_nodone"}, k + 2 + j, W_IDLE);
        end
        return;
      end
      data_in = alt;
      if (k < arm - 1) start = 1'b1;
      else if (pulses && (k >= arm) && (k < arm + 12 + bi)) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      if (chain && (k == arm + 12 + bi)) begin
        start   = 1'b1;
        data_in = next_b;
      end
    end
  endtask

  initial begin
    vecs[0] = '{data: 8'h05, arm: 1, alt: 8'h05, pulses: 1'b0, abort_k: -1};
    vecs[1] = '{data: 8'h5A, arm: 6, alt: 8'hFF, pulses: 1'b0, abort_k: -1};
    vecs[2] = '{data: 8'h00, arm: 1, alt: 8'h00, pulses: 1'b0, abort_k: -1};
    vecs[3] = '{data: 8'hFF, arm: 1, alt: 8'hFF, pulses: 1'b1, abort_k: -1};
    vecs[4] = '{data: 8'h3C, arm: 1, alt: 8'h3C, pulses: 1'b0, abort_k: 7};
    vecs[5] = '{data: 8'hA3, arm: 1, alt: 8'hA3, pulses: 1'b0, abort_k: -1};
    vecs[6] = '{data: 8'h01, arm: 2, alt: 8'h00, pulses: 1'b1, abort_k: -1};
    vecs[7] = '{data: 8'h80, arm: 1, alt: 8'h80, pulses: 1'b0, abort_k: -1};

    // reset then idle
    rst     = 1'b1;
    start   = 1'b0;
    data_in = 8'h00;
    @(negedge clk);
    check_word("reset", 0, W_IDLE);
    @(negedge clk);
    check_word("reset", 1, W_IDLE);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_word("idle", i, W_IDLE);
    end

    // table-driven frames
    for (int v = 0; v < 8; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].arm, vecs[v].alt,
                vecs[v].pulses, vecs[v].abort_k, 1'b0, 1'b0, 8'h00);
    end

    // back-to-back: start high in the done cycle launches the next frame
    run_frame("chain_a", 8'h02, 1, 8'h02, 1'b0, -1, 1'b0, 1'b1, 8'h11);
    run_frame("chain_b", 8'h11, 1, 8'h11, 1'b0, -1, 1'b1, 1'b0, 8'h00);

    // reset during ARM, then recovery frame
    start   = 1'b1;
    data_in = 8'h77;
    @(negedge clk);
    check_word("arm_rst", 0, W_BUSY);
    rst = 1'b1;
    @(negedge clk);
    check_word("arm_rst", 1, W_IDLE);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_word("arm_rst", 2, W_IDLE);
    run_frame("post_rst", 8'h03, 1, 8'h03, 1'b0, -1, 1'b0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
